alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 8-bit `alu` datapath (ADD/SUB/AND/OR) between two requesters. Each requester issues an operation over a valid/ready handshake. The block captures the operands, drives the ALU for one cycle and registers the result. It returns the result with the requester id over a response handshake. It sits between the two issuing units (sequencer/console ports) and the ALU, and is the only block that drives ALU inputs.

---
 rtl/alu_arbiter_pkg.sv | 22 ++
 rtl/alu_arbiter_alu.sv | 30 +++
 rtl/alu_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared opcode, FSM-state and captured-request definitions for the ALU arbiter.
package alu_arbiter_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       id;
    } cap_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared 8-bit ALU (ADD/SUB/AND/OR); op[0] is also the subtract carry-in.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [1:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y,
    output logic       cout
);

    logic [7:0] b_eff;
    logic [8:0] sum;

    // SUB is a + ~b + 1, with the +1 supplied by op[0]
    assign b_eff = op[0] ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {8'd0, op[0]};

    always_comb begin
        y    = sum[7:0];
        cout = sum[8];
        case (op)
            OP_ADD, OP_SUB: y = sum[7:0];
            OP_AND:         y = a & b;
            OP_OR:          y = a | b;
            default:        y = sum[7:0];
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a
// registered, back-pressured response channel.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter logic PRIO_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [1:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       rsp_zero,
    output logic       busy
);

    state_t     state_q, state_d;
    logic       prio_q, prio_d;
    cap_t       cap_q, cap_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_id_q, rsp_id_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_zero_q, rsp_zero_d;
    logic       busy_q, busy_d;

    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic       grant;
    logic       accept;
    logic [7:0] alu_y;
    logic       alu_cout_unused;

    assign req_valid = {req1_valid, req0_valid};

    // Priority pointer only matters when both requesters are valid
    assign grant = (req0_valid && req1_valid) ? prio_q : req1_valid;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign req_ready[gi] = (state_q == S_IDLE) && !reset &&
                               req_valid[gi] && (grant == 1'(gi));
    end

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign accept     = |req_ready;

    alu u_alu (
        .op   (cap_q.op),
        .a    (cap_q.a),
        .b    (cap_q.b),
        .y    (alu_y),
        .cout (alu_cout_unused)
    );

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        cap_d      = cap_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cap_d.op = grant ? req1_op : req0_op;
                    cap_d.a  = grant ? req1_a  : req0_a;
                    cap_d.b  = grant ? req1_b  : req0_b;
                    cap_d.id = grant;
                    prio_d   = ~grant;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d = alu_y;
                rsp_zero_d = (alu_y == 8'h00);
                rsp_id_d   = cap_q.id;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        rsp_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            prio_q      <= PRIO_RESET;
            cap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            cap_q       <= cap_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: vector table for single operations, a response
// scoreboard, and hand-written round-robin, back-pressure and abort sequences.
module tb_alu_arbiter;

    logic       clk;
    logic       reset;
    logic       req0_valid, req0_ready;
    logic [1:0] req0_op;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready;
    logic [1:0] req1_op;
    logic [7:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
    logic [7:0] rsp_data;

    alu_arbiter #(.PRIO_RESET(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_data;
        logic       exp_zero;
    } vec_t;

    typedef struct {
        logic       id;
        logic [7:0] data;
        logic       zero;
    } rsp_t;

    vec_t vecs[6];
    rsp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   mon_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic rsp_t model(input logic id, input logic [1:0] op,
                                   input logic [7:0] a, input logic [7:0] b);
        rsp_t r;
        r.id = id;
        case (op)
            2'b00:   r.data = a + b;
            2'b01:   r.data = a - b;
            2'b10:   r.data = a & b;
            default: r.data = a | b;
        endcase
        r.zero = (r.data == 8'h00);
        return r;
    endfunction

    // Scoreboard: push on accepted request, pop on completed response
    always @(negedge clk) begin
        if (mon_en) begin
            if (reset) begin
                sb_q.delete();
            end else begin
                if (req0_valid && req0_ready) sb_q.push_back(model(1'b0, req0_op, req0_a, req0_b));
                if (req1_valid && req1_ready) sb_q.push_back(model(1'b1, req1_op, req1_a, req1_b));
                if (rsp_valid && rsp_ready) begin
                    if (sb_q.size() == 0) begin
                        n_total++;
                        $display("FAIL sb_unexpected: got response id %0d data 0x%0h, expected none",
                                 rsp_id, rsp_data);
                    end else begin
                        rsp_t e;
                        e = sb_q.pop_front();
                        $display("rsp id=%0d data=0x%02h zero=%0d", rsp_id, rsp_data, rsp_zero);
                        chk("sb_id", 32'(rsp_id), 32'(e.id));
                        chk("sb_data", 32'(rsp_data), 32'(e.data));
                        chk("sb_zero", 32'(rsp_zero), 32'(e.zero));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        tick();
        rsp_ready = 1'b1;
        if (v.id == 1'b0) begin
            req0_op = v.op; req0_a = v.a; req0_b = v.b; req0_valid = 1'b1;
        end else begin
            req1_op = v.op; req1_a = v.a; req1_b = v.b; req1_valid = 1'b1;
        end
        @(negedge clk);
        chk("vec_accept", 32'(v.id ? req1_ready : req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("vec_exec_busy", 32'(busy), 32'd1);
        chk("vec_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("vec_rsp_data", 32'(rsp_data), 32'(v.exp_data));
        chk("vec_rsp_id", 32'(rsp_id), 32'(v.id));
        chk("vec_rsp_zero", 32'(rsp_zero), 32'(v.exp_zero));
        tick();
        @(negedge clk);
        chk("vec_idle_busy", 32'(busy), 32'd0);
        chk("vec_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int gid[$];
        int gcyc[$];

        vecs[0] = '{1'b0, 2'b00, 8'h05, 8'h03, 8'h08, 1'b0};
        vecs[1] = '{1'b1, 2'b01, 8'h03, 8'h05, 8'hFE, 1'b0};
        vecs[2] = '{1'b1, 2'b01, 8'h20, 8'h20, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[4] = '{1'b0, 2'b10, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[5] = '{1'b1, 2'b11, 8'hF0, 8'h0F, 8'hFF, 1'b0};

        reset = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'h11; req0_b = 8'h22;
        req1_valid = 1'b0; req1_op = 2'b00; req1_a = 8'h00; req1_b = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready0", 32'(req0_ready), 32'd0);
        tick();
        reset = 1'b0;
        req0_valid = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_rsp_zero", 32'(rsp_zero), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Single requests; alternating ids also show a lone valid is granted regardless of prio
        for (int i = 0; i < 6; i++) begin
            $display("vec %0d: id=%0d op=%0d a=0x%02h b=0x%02h", i, vecs[i].id, vecs[i].op,
                     vecs[i].a, vecs[i].b);
            run_vec(vecs[i]);
        end

        // Both valid continuously: grants must alternate 0,1,0,1 every 3 cycles
        tick();
        req0_op = 2'b10; req0_a = 8'hF0; req0_b = 8'h3C; req0_valid = 1'b1;
        req1_op = 2'b11; req1_a = 8'hF0; req1_b = 8'h0F; req1_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                gid.push_back(req1_ready ? 1 : 0);
                gcyc.push_back(cyc);
                $display("rr grant id=%0d cycle=%0d", req1_ready ? 1 : 0, cyc);
            end
            if (cyc < 11) tick();
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_grant_count", 32'(gid.size()), 32'd4);
        if (gid.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("rr_grant_id", 32'(gid[k]), 32'(k % 2));
                if (k > 0) chk("rr_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
            end
        end
        repeat (2) tick();

        // Back-pressure: response held for 5 cycles with rsp_ready low
        req0_op = 2'b00; req0_a = 8'h10; req0_b = 8'h22; req0_valid = 1'b1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_accept", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_op = 2'b01; req1_a = 8'h50; req1_b = 8'h08; req1_valid = 1'b1;
        @(negedge clk);
        chk("bp_exec_ready1", 32'(req1_ready), 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            $display("bp hold %0d: rsp_valid=%0d data=0x%02h", k, rsp_valid, rsp_data);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'h32);
            chk("bp_rsp_id", 32'(rsp_id), 32'd0);
            chk("bp_ready1", 32'(req1_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("bp_next_accept", 32'(req1_ready), 32'd1);
        chk("bp_idle_busy", 32'(busy), 32'd0);
        tick();
        req1_valid = 1'b0;
        repeat (3) tick();

        // Reset during EXEC: no response, outputs and prio back to reset values
        req0_op = 2'b00; req0_a = 8'h01; req0_b = 8'h01; req0_valid = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("abort_accept", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_exec_busy", 32'(busy), 32'd1);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rsp_data", 32'(rsp_data), 32'd0);
        chk("abort_rsp_id", 32'(rsp_id), 32'd0);
        chk("abort_rsp_zero", 32'(rsp_zero), 32'd0);
        tick();
        @(negedge clk);
        chk("abort_no_late_rsp", 32'(rsp_valid), 32'd0);
        tick();
        req0_op = 2'b10; req0_a = 8'hF0; req0_b = 8'h3C; req0_valid = 1'b1;
        req1_op = 2'b11; req1_a = 8'hF0; req1_b = 8'h0F; req1_valid = 1'b1;
        @(negedge clk);
        chk("abort_prio_ready0", 32'(req0_ready), 32'd1);
        chk("abort_prio_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) tick();

        @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
